// File: rtl/clock_divider_pkg.sv
// Shared types and constants for the SPI-style clock divider.
// The divisor clamp lives here so the reset value and latched values follow one rule.
package clock_divider_pkg;

  localparam int DIV_WIDTH        = 8;
  localparam int PERIOD_CNT_WIDTH = 4;
  localparam int DEFAULT_DIVISOR  = 2;
  localparam int NUM_PERIODS      = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONFIG = 2'd1,
    RUN    = 2'd2
  } state_t;

  // A divide-by-0 or divide-by-1 cannot produce a low and a high phase, so both become 2.
  function automatic logic [DIV_WIDTH-1:0] clamp_divisor(input logic [DIV_WIDTH-1:0] d);
    return (d < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : d;
  endfunction

endpackage

// File: rtl/clock_divider.sv
// Generates NUM_PERIODS periods of a divided clock per run request.
// Each period is low for ceil(D/2) cycles, then high for floor(D/2) cycles.
module clock_divider #(
  parameter int DEFAULT_DIVISOR = clock_divider_pkg::DEFAULT_DIVISOR,
  parameter int NUM_PERIODS     = clock_divider_pkg::NUM_PERIODS
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [8:0] i_config,
  input  logic       i_start_n,
  output logic       o_ready,
  output logic       o_clk
);

  import clock_divider_pkg::*;

  localparam logic [PERIOD_CNT_WIDTH-1:0] LAST_PERIOD   = PERIOD_CNT_WIDTH'(NUM_PERIODS - 1);
  localparam logic [DIV_WIDTH-1:0]        RESET_DIVISOR = clamp_divisor(DIV_WIDTH'(DEFAULT_DIVISOR));

  state_t                      state, state_n;
  logic [DIV_WIDTH-1:0]        divisor, divisor_n;
  logic [DIV_WIDTH-1:0]        cycle_cnt, cycle_cnt_n;
  logic [PERIOD_CNT_WIDTH-1:0] period_cnt, period_cnt_n;
  logic                        ready_n, clk_n;
  logic                        strobe;
  logic [DIV_WIDTH-1:0]        cfg_divisor;
  logic [DIV_WIDTH:0]          low_len;

  assign strobe      = i_config[0];
  assign cfg_divisor = i_config[DIV_WIDTH:1];
  // One extra bit keeps ceil(D/2) exact for D=255.
  assign low_len     = ({1'b0, divisor} + 1'b1) >> 1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      divisor    <= RESET_DIVISOR;
      cycle_cnt  <= '0;
      period_cnt <= '0;
      o_ready    <= 1'b1;
      o_clk      <= 1'b0;
    end else begin
      state      <= state_n;
      divisor    <= divisor_n;
      cycle_cnt  <= cycle_cnt_n;
      period_cnt <= period_cnt_n;
      o_ready    <= ready_n;
      o_clk      <= clk_n;
    end
  end

  // o_clk and o_ready are computed for the next cycle so both leave a flop directly.
  always_comb begin
    state_n      = state;
    divisor_n    = divisor;
    cycle_cnt_n  = cycle_cnt;
    period_cnt_n = period_cnt;
    clk_n        = 1'b0;

    case (state)
      IDLE: begin
        cycle_cnt_n  = '0;
        period_cnt_n = '0;
        if (strobe) begin
          divisor_n = clamp_divisor(cfg_divisor);
          state_n   = CONFIG;
        end else if (!i_start_n) begin
          state_n = RUN;
        end
      end
      CONFIG: begin
        if (!strobe) state_n = IDLE;
      end
      RUN: begin
        if (cycle_cnt == divisor - DIV_WIDTH'(1)) begin
          cycle_cnt_n = '0;
          if (period_cnt == LAST_PERIOD) begin
            period_cnt_n = '0;
            state_n      = IDLE;
          end else begin
            period_cnt_n = period_cnt + 1'b1;
          end
        end else begin
          cycle_cnt_n = cycle_cnt + 1'b1;
        end
        if (state_n == RUN) clk_n = ({1'b0, cycle_cnt_n} >= low_len);
      end
      default: state_n = IDLE;
    endcase

    ready_n = (state_n == IDLE);
  end

endmodule

// File: tb/tb_clock_divider.sv
// Self-checking bench for clock_divider: directed divisor table, corner sequences,
// and randomized divisors checked against an arithmetic model of the waveform.
module tb_clock_divider;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [8:0] i_config;
  logic       i_start_n;
  logic       o_ready;
  logic       o_clk;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int cfg_d;
    int exp_d;
    int exp_busy;
    int exp_low;
    int exp_high;
  } vec_t;

  vec_t vecs[8];

  clock_divider #(.DEFAULT_DIVISOR(2), .NUM_PERIODS(8)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_config  (i_config),
    .i_start_n (i_start_n),
    .o_ready   (o_ready),
    .o_clk     (o_clk)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int d, input logic strobe, input logic start_n);
    i_config  = {d[7:0], strobe};
    i_start_n = start_n;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Model: a divisor below 2 acts as 2; low phase ceil(D/2), high phase floor(D/2).
  function automatic int eff_div(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic configure(input int d);
    int n = 0;
    applyStimulus(d, 1'b1, 1'b1);
    tick();
    while (o_ready === 1'b1 && n < 4) begin
      tick();
      n++;
    end
    checkOutput("config_ready_low", int'(o_ready), 0);
    checkOutput("config_clk_low", int'(o_clk), 0);
    applyStimulus(d, 1'b0, 1'b1);
    tick();
    checkOutput("config_ready_back", int'(o_ready), 1);
  endtask

  task automatic start_run(input bit hold);
    i_config  = '0;
    i_start_n = 1'b0;
    tick();
    checkOutput("start_ready_low", int'(o_ready), 0);
    if (!hold) i_start_n = 1'b1;
  endtask

  // Called at the first sample of a run; samples each cycle until o_ready returns.
  task automatic measure_run(input int d, input int low, input int high, input int exp_busy,
                             input bit noise);
    int   k = 0, rises = 0, highs = 0, errs = 0;
    logic prev = 1'b0;
    logic exp_clk;
    while (o_ready === 1'b0 && k < exp_busy + 20) begin
      exp_clk = ((k % d) >= low);
      if (o_clk !== exp_clk) errs++;
      if (o_clk === 1'b1) highs++;
      if (o_clk === 1'b1 && prev === 1'b0) rises++;
      prev = o_clk;
      if (noise) applyStimulus(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                               1'($urandom_range(0, 1)));
      k++;
      tick();
    end
    if (noise) applyStimulus(0, 1'b0, 1'b1);
    checkOutput("run_busy_cycles", k, exp_busy);
    checkOutput("run_rising_edges", rises, 8);
    checkOutput("run_high_cycles", highs, 8 * high);
    checkOutput("run_clk_wave_errors", errs, 0);
    checkOutput("run_end_ready", int'(o_ready), 1);
    checkOutput("run_end_clk", int'(o_clk), 0);
  endtask

  initial begin
    int errs;
    int d, e;

    vecs[0] = '{250, 250, 2000, 125, 125};
    vecs[1] = '{100, 100,  800,  50,  50};
    vecs[2] = '{  4,   4,   32,   2,   2};
    vecs[3] = '{  2,   2,   16,   1,   1};
    vecs[4] = '{  3,   3,   24,   2,   1};
    vecs[5] = '{  0,   2,   16,   1,   1};
    vecs[6] = '{  1,   2,   16,   1,   1};
    vecs[7] = '{255, 255, 2040, 128, 127};

    // Reset held for 16 cycles, then released.
    applyStimulus(0, 1'b0, 1'b1);
    i_rst = 1'b1;
    repeat (16) tick();
    checkOutput("reset_ready", int'(o_ready), 1);
    checkOutput("reset_clk", int'(o_clk), 0);
    i_rst = 1'b0;
    tick();
    checkOutput("post_reset_ready", int'(o_ready), 1);
    checkOutput("post_reset_clk", int'(o_clk), 0);

    // Default divisor after reset is 2.
    start_run(1'b0);
    measure_run(2, 1, 1, 16, 1'b0);

    foreach (vecs[i]) begin
      configure(vecs[i].cfg_d);
      start_run(1'b0);
      measure_run(vecs[i].exp_d, vecs[i].exp_low, vecs[i].exp_high, vecs[i].exp_busy, 1'b0);
    end

    // Strobe and start together: configuration wins, no clock activity.
    applyStimulus(5, 1'b1, 1'b0);
    tick();
    checkOutput("both_ready_low", int'(o_ready), 0);
    errs = 0;
    repeat (4) begin
      if (o_clk !== 1'b0) errs++;
      tick();
    end
    checkOutput("both_no_clk", errs, 0);
    applyStimulus(5, 1'b0, 1'b1);
    tick();
    checkOutput("both_ready_back", int'(o_ready), 1);
    checkOutput("both_clk_idle", int'(o_clk), 0);
    start_run(1'b0);
    measure_run(5, 3, 2, 40, 1'b0);

    // Start held low across the end of a run: one IDLE cycle, then a second run.
    configure(4);
    start_run(1'b1);
    measure_run(4, 2, 2, 32, 1'b0);
    tick();
    checkOutput("held_start_second_run", int'(o_ready), 0);
    i_start_n = 1'b1;
    measure_run(4, 2, 2, 32, 1'b0);

    // Random divisors; config noise during the first run must not change D.
    repeat (6) begin
      d = int'($urandom_range(0, 40));
      e = eff_div(d);
      configure(d);
      start_run(1'b0);
      measure_run(e, (e + 1) / 2, e / 2, 8 * e, 1'b1);
      start_run(1'b0);
      measure_run(e, (e + 1) / 2, e / 2, 8 * e, 1'b0);
    end

    // Reset 37 cycles into a D=100 run aborts it and restores the default divisor.
    configure(100);
    start_run(1'b0);
    repeat (36) tick();
    checkOutput("midrun_busy_before_reset", int'(o_ready), 0);
    #2 i_rst = 1'b1;
    #1;
    checkOutput("midrun_reset_ready", int'(o_ready), 1);
    checkOutput("midrun_reset_clk", int'(o_clk), 0);
    tick();
    i_rst = 1'b0;
    tick();
    checkOutput("midrun_post_ready", int'(o_ready), 1);
    start_run(1'b0);
    measure_run(2, 1, 1, 16, 1'b0);

    // Reset while o_clk is high must force it low without waiting for an edge.
    configure(10);
    start_run(1'b0);
    repeat (6) tick();
    checkOutput("high_phase_before_reset", int'(o_clk), 1);
    #2 i_rst = 1'b1;
    #1;
    checkOutput("high_phase_reset_clk", int'(o_clk), 0);
    checkOutput("high_phase_reset_ready", int'(o_ready), 1);
    tick();
    i_rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/clock_divider.md
CLOCK_DIVIDER -- requirements
Module: clock_divider

Interface
REQ-001 Parameter DEFAULT_DIVISOR, 2, divisor loaded at reset.
REQ-002 Parameter NUM_PERIODS, 8, o_clk periods generated per run (one SPI byte).
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 i_clk  input  1  system clock; all state updates on its rising edge.
REQ-005 i_rst  input  1  asynchronous active-high reset.
REQ-006 i_config  input  9  bit 0 = configure strobe (level, active-high); bits [8:1] = divisor D.
REQ-007 i_start_n  input  1  active-low run request (level).
REQ-008 o_ready  output  1  high only in IDLE; registered.
REQ-009 o_clk  output  1  divided clock; low when not running; registered.

Function
REQ-010 The block SHALL implement the states IDLE, CONFIG and RUN.
REQ-011 In IDLE, with i_config[0]=1, the block SHALL latch i_config[8:1] into the divisor register and enter CONFIG on the next edge.
REQ-012 In IDLE, with i_config[0]=0 and i_start_n=0, the block SHALL enter RUN on the next edge.
REQ-013 If the strobe and start are both active in IDLE, configuration SHALL take priority.
REQ-014 CONFIG SHALL hold o_ready=0 and return to IDLE on the first edge where i_config[0]=0, so that one strobe gives exactly one configuration.
REQ-015 A latched divisor below 2 (0 or 1) SHALL be replaced by 2.
REQ-016 RUN SHALL last exactly NUM_PERIODS*D cycles with o_ready=0, then return to IDLE with o_ready=1 and o_clk=0 on the following edge.
REQ-017 Each o_clk period SHALL be D cycles: low for ceil(D/2) cycles, then high for floor(D/2) cycles, starting low.
REQ-018 A divisor change during RUN is impossible because config is accepted only in IDLE, so D SHALL be stable throughout a run.
REQ-019 i_config and i_start_n SHALL be ignored in RUN.
REQ-020 If i_start_n is still low when RUN ends, the block SHALL spend at least one cycle in IDLE (o_ready=1) before starting a new run.
REQ-021 Counters SHALL be: an 8-bit cycle-within-period counter (0..D-1) and a 4-bit period counter (0..NUM_PERIODS-1); both SHALL clear on entering RUN.
REQ-022 o_clk SHALL be glitch-free, driven directly from a flop.

Reset
REQ-023 While i_rst=1, asynchronously: state=IDLE, o_ready=1, o_clk=0, divisor=DEFAULT_DIVISOR, all counters 0.
REQ-024 Reset asserted mid-CONFIG or mid-RUN SHALL abort the operation immediately with the values of REQ-023.
REQ-025 After reset release, the block SHALL accept a strobe or start on the first edge.

Structure
REQ-026 A package clock_divider_pkg SHALL hold the state enum (IDLE, CONFIG, RUN), DEFAULT_DIVISOR, NUM_PERIODS and the divisor width (8).
REQ-027 The block SHALL be a single module with no sub-module; the FSM and counters SHALL be inline.

Verification
REQ-028 Reset: hold i_rst=1 for 16 cycles, then release -> o_ready=1 and o_clk=0 on the next edge.
REQ-029 Configure D=250: i_config={250,1} until o_ready falls, then 0 -> o_ready returns to 1; start run -> o_ready low for exactly 2000 cycles, o_clk 125 low/125 high ×8, end o_ready=1, o_clk=0.
REQ-030 D=100 and D=4: run -> busy 800 and 32 cycles respectively; o_clk period 100/4 cycles; 8 rising edges counted.
REQ-031 D=2: run -> o_clk alternates 1 low/1 high, 16 cycles busy; D=3 -> 2 low/1 high, 24 cycles busy; D=0 or 1 -> behaves as D=2.
REQ-032 Strobe and start together in IDLE -> CONFIG only, no o_clk edges; start held low across run end -> one IDLE cycle, then a second run.
REQ-033 Reset asserted 37 cycles into a D=100 run -> o_ready=1 and o_clk=0 immediately; divisor back to 2.
